// File: rtl/alu_pipe_if.sv
// Issue/writeback bundle for alu_pipe. Inputs and outputs both transfer on a cycle where valid & ready are high;
// valid never waits for ready, and a producer holds its payload stable while valid & !ready.
interface alu_pipe_if #(
  parameter int XLEN       = 64,
  parameter int PC_W       = 48,
  parameter int ROBID_W    = 7,
  parameter int PRD_W      = 6,
  parameter int ALU_TYPE_W = 14
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [XLEN-1:0]       in_src1;
    logic [XLEN-1:0]       in_src2;
    logic [XLEN-1:0]       in_imm;
    logic [PC_W-1:0]       in_pc;
    logic [ALU_TYPE_W-1:0] in_alu_type;
    logic                  in_is_word;
    logic                  in_is_unsigned;
    logic                  in_is_imm;
    logic [ROBID_W-1:0]    in_robid;
    logic [PRD_W-1:0]      in_prd;
    logic                  flush_valid;
    logic [ROBID_W-1:0]    flush_robid;
    logic                  out_valid;
    logic                  out_ready;
    logic [XLEN-1:0]       out_result;
    logic [ROBID_W-1:0]    out_robid;
    logic [PRD_W-1:0]      out_prd;

    modport master (
        output in_valid, in_src1, in_src2, in_imm, in_pc, in_alu_type, in_is_word,
               in_is_unsigned, in_is_imm, in_robid, in_prd, flush_valid, flush_robid, out_ready,
        input  in_ready, out_valid, out_result, out_robid, out_prd
    );

    modport slave (
        input  in_valid, in_src1, in_src2, in_imm, in_pc, in_alu_type, in_is_word,
               in_is_unsigned, in_is_imm, in_robid, in_prd, flush_valid, flush_robid, out_ready,
        output in_ready, out_valid, out_result, out_robid, out_prd
    );
endinterface

// File: rtl/alu_pipe.sv
// Pipelined integer ALU (1 or 2 stages) with valid/ready flow control and ROB-age flush.
// Optional shift-add ops (SH1ADD/SH2ADD/SH3ADD) are built only when ALU_ZBA_EN is defined.
module alu_pipe #(
  parameter int XLEN       = 64,
  parameter int PC_W       = 48,
  parameter int STAGES     = 2,
  parameter int ROBID_W    = 7,
  parameter int PRD_W      = 6,
  parameter int ALU_TYPE_W = 14
) (
    input logic      clock,
    input logic      reset,
    alu_pipe_if.slave bus
);

    localparam int IDX_W = ROBID_W - 1;

    // a is younger than b; the MSB wrap bit flips the index ordering
    function automatic logic younger(input logic [ROBID_W-1:0] a, input logic [ROBID_W-1:0] b);
        if (a[ROBID_W-1] != b[ROBID_W-1]) return a[IDX_W-1:0] < b[IDX_W-1:0];
        else return a[IDX_W-1:0] > b[IDX_W-1:0];
    endfunction

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
        logic [XLEN-1:0] r;
        r       = {XLEN{x[31]}};
        r[31:0] = x;
        return r;
    endfunction

    logic                  in_rdy;
    logic                  sel_imm;
    logic [XLEN-1:0]       in_op1;
    logic [XLEN-1:0]       in_op2;

    logic                  p_valid;
    logic [XLEN-1:0]       p_op1;
    logic [XLEN-1:0]       p_op2;
    logic [ALU_TYPE_W-1:0] p_type;
    logic                  p_word;
    logic                  p_uns;
    logic [ROBID_W-1:0]    p_robid;
    logic [PRD_W-1:0]      p_prd;
    logic                  kill_p;

    logic                  v1;
    logic [XLEN-1:0]       r1_result;
    logic [ROBID_W-1:0]    r1_robid;
    logic [PRD_W-1:0]      r1_prd;
    logic                  s1_take;
    logic                  kill_s1;

    // SUB has no immediate form; LUI and AUIPC always take the immediate
    assign sel_imm = (bus.in_is_imm & ~bus.in_alu_type[8]) | bus.in_alu_type[9] | bus.in_alu_type[10];
    assign in_op1  = bus.in_alu_type[10] ? XLEN'(bus.in_pc) : bus.in_src1;
    assign in_op2  = sel_imm ? bus.in_imm : bus.in_src2;

    assign s1_take = ~v1 | bus.out_ready;
    assign kill_p  = bus.flush_valid & younger(p_robid, bus.flush_robid);
    assign kill_s1 = bus.flush_valid & younger(r1_robid, bus.flush_robid);

    generate
        if (STAGES == 2) begin : g_s0
            logic                  v0;
            logic [XLEN-1:0]       r0_op1;
            logic [XLEN-1:0]       r0_op2;
            logic [ALU_TYPE_W-1:0] r0_type;
            logic                  r0_word;
            logic                  r0_uns;
            logic [ROBID_W-1:0]    r0_robid;
            logic [PRD_W-1:0]      r0_prd;
            logic                  kill_in;

            assign kill_in = bus.flush_valid & younger(bus.in_robid, bus.flush_robid);
            assign in_rdy  = ~v0 | s1_take;

            always_ff @(posedge clock) begin
                if (reset) begin
                    v0       <= 1'b0;
                    r0_op1   <= '0;
                    r0_op2   <= '0;
                    r0_type  <= '0;
                    r0_word  <= 1'b0;
                    r0_uns   <= 1'b0;
                    r0_robid <= '0;
                    r0_prd   <= '0;
                end else if (in_rdy) begin
                    v0 <= bus.in_valid & ~kill_in;
                    if (bus.in_valid) begin
                        r0_op1   <= in_op1;
                        r0_op2   <= in_op2;
                        r0_type  <= bus.in_alu_type;
                        r0_word  <= bus.in_is_word;
                        r0_uns   <= bus.in_is_unsigned;
                        r0_robid <= bus.in_robid;
                        r0_prd   <= bus.in_prd;
                    end
                end else begin
                    v0 <= v0 & ~kill_p;
                end
            end

            assign p_valid = v0;
            assign p_op1   = r0_op1;
            assign p_op2   = r0_op2;
            assign p_type  = r0_type;
            assign p_word  = r0_word;
            assign p_uns   = r0_uns;
            assign p_robid = r0_robid;
            assign p_prd   = r0_prd;
        end else begin : g_direct
            assign in_rdy  = s1_take;
            assign p_valid = bus.in_valid;
            assign p_op1   = in_op1;
            assign p_op2   = in_op2;
            assign p_type  = bus.in_alu_type;
            assign p_word  = bus.in_is_word;
            assign p_uns   = bus.in_is_unsigned;
            assign p_robid = bus.in_robid;
            assign p_prd   = bus.in_prd;
        end
    endgenerate

    logic            type_ok;
    logic [5:0]      sh;
    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] diff;
    logic [XLEN-1:0] x_sra;
    logic [31:0]     w_sll;
    logic [31:0]     w_srl;
    logic [31:0]     w_sra;
    logic            lt;
    logic [XLEN-1:0] alu_res;
`ifdef ALU_ZBA_EN
    logic [XLEN-1:0] op1z;
`endif

    always_comb begin
        type_ok = (p_type != '0) && ((p_type & (p_type - ALU_TYPE_W'(1))) == '0);
`ifndef ALU_ZBA_EN
        type_ok = type_ok && (p_type[13:11] == 3'b000);
`endif
        sh    = (p_word || XLEN == 32) ? {1'b0, p_op2[4:0]} : p_op2[5:0];
        sum   = p_op1 + p_op2;
        diff  = p_op1 - p_op2;
        x_sra = $signed(p_op1) >>> sh;
        w_sll = p_op1[31:0] << sh[4:0];
        w_srl = p_op1[31:0] >> sh[4:0];
        w_sra = $signed(p_op1[31:0]) >>> sh[4:0];
        lt    = p_uns ? (p_op1 < p_op2) : ($signed(p_op1) < $signed(p_op2));
`ifdef ALU_ZBA_EN
        op1z = p_op1;
        if (p_word) begin
            op1z       = '0;
            op1z[31:0] = p_op1[31:0];
        end
`endif
        alu_res = '0;
        if (type_ok) begin
            if (p_type[0] | p_type[10]) alu_res = (p_word && p_type[0]) ? sext32(sum[31:0]) : sum;
            if (p_type[8]) alu_res = p_word ? sext32(diff[31:0]) : diff;
            if (p_type[1]) alu_res[0] = lt;
            if (p_type[2]) alu_res = p_op1 ^ p_op2;
            if (p_type[3]) alu_res = p_op1 | p_op2;
            if (p_type[4]) alu_res = p_op1 & p_op2;
            if (p_type[5]) alu_res = p_word ? sext32(w_sll) : (p_op1 << sh);
            if (p_type[6]) alu_res = p_word ? sext32(w_srl) : (p_op1 >> sh);
            if (p_type[7]) alu_res = p_word ? sext32(w_sra) : x_sra;
            if (p_type[9]) alu_res = p_op2;
`ifdef ALU_ZBA_EN
            if (p_type[11]) alu_res = (op1z << 1) + p_op2;
            if (p_type[12]) alu_res = (op1z << 2) + p_op2;
            if (p_type[13]) alu_res = (op1z << 3) + p_op2;
`endif
        end
    end

    // a stalled output entry can still be killed; it is never replaced in the same cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            v1        <= 1'b0;
            r1_result <= '0;
            r1_robid  <= '0;
            r1_prd    <= '0;
        end else if (s1_take) begin
            v1 <= p_valid & ~kill_p;
            if (p_valid) begin
                r1_result <= alu_res;
                r1_robid  <= p_robid;
                r1_prd    <= p_prd;
            end
        end else begin
            v1 <= v1 & ~kill_s1;
        end
    end

    assign bus.in_ready   = in_rdy;
    assign bus.out_valid  = v1;
    assign bus.out_result = r1_result;
    assign bus.out_robid  = r1_robid;
    assign bus.out_prd    = r1_prd;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed ALU ops, back-pressure, flush and reset cases, plus a random stream.
module tb_alu_pipe;
  localparam int XLEN = 64;
  localparam int PC_W = 48;
  localparam int STAGES = 2;
  localparam int ROBID_W = 7;
  localparam int PRD_W = 6;
  localparam int ALU_TYPE_W = 14;
  localparam int W = ROBID_W + PRD_W + XLEN;

  localparam logic [13:0] T_ADD = 14'd1;
  localparam logic [13:0] T_SLT = 14'd2;
  localparam logic [13:0] T_XOR = 14'd4;
  localparam logic [13:0] T_OR = 14'd8;
  localparam logic [13:0] T_AND = 14'd16;
  localparam logic [13:0] T_SLL = 14'd32;
  localparam logic [13:0] T_SRL = 14'd64;
  localparam logic [13:0] T_SRA = 14'd128;
  localparam logic [13:0] T_SUB = 14'd256;
  localparam logic [13:0] T_LUI = 14'd512;
  localparam logic [13:0] T_AUIPC = 14'd1024;
  localparam logic [13:0] T_SH2 = 14'd4096;

  logic clock;
  logic reset;
  int total = 0;
  int bad = 0;
  logic [W-1:0] exp_q[$];

  alu_pipe_if #(.XLEN(XLEN), .PC_W(PC_W), .ROBID_W(ROBID_W), .PRD_W(PRD_W), .ALU_TYPE_W(ALU_TYPE_W)) bus ();

  alu_pipe #(.XLEN(XLEN), .PC_W(PC_W), .STAGES(STAGES), .ROBID_W(ROBID_W), .PRD_W(PRD_W),
             .ALU_TYPE_W(ALU_TYPE_W)) dut (.clock(clock), .reset(reset), .bus(bus));

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // driver: present one op until accepted; expectation pushed on acceptance when keep is set
  task automatic sendx(input logic [13:0] t, input logic [63:0] s1, input logic [63:0] s2,
                       input logic [63:0] imm, input logic [47:0] pc, input logic w, input logic u,
                       input logic im, input logic [6:0] rid, input logic [63:0] exp, input bit keep);
    logic acc;
    int n;
    logic [5:0] prd;
    prd = rid[5:0] ^ 6'h2A;
    bus.in_valid = 1'b1;
    bus.in_alu_type = t;
    bus.in_src1 = s1;
    bus.in_src2 = s2;
    bus.in_imm = imm;
    bus.in_pc = pc;
    bus.in_is_word = w;
    bus.in_is_unsigned = u;
    bus.in_is_imm = im;
    bus.in_robid = rid;
    bus.in_prd = prd;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 100) begin
      @(negedge clock);
      acc = bus.in_ready;
      @(posedge clock);
      #1;
      n++;
    end
    check("send_accept", W'(acc), W'(1));
    if (acc && keep) exp_q.push_back({rid, prd, exp});
    bus.in_valid = 1'b0;
  endtask

  task automatic op(input logic [13:0] t, input logic [63:0] s1, input logic [63:0] s2,
                    input logic w, input logic u, input logic [6:0] rid, input logic [63:0] exp);
    sendx(t, s1, s2, 64'd0, 48'd0, w, u, 1'b0, rid, exp, 1'b1);
  endtask

  task automatic pulse_flush(input logic [6:0] rid);
    bus.flush_valid = 1'b1;
    bus.flush_robid = rid;
    @(posedge clock);
    #1;
    bus.flush_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clock);
      n++;
    end
    #1;
    check(tag, W'(exp_q.size()), W'(0));
  endtask

  // scoreboard: every output handshake pops one expectation; stalled outputs must hold still
  logic stall_prev = 1'b0;
  logic [W-1:0] held;
  always @(negedge clock) begin
    logic [W-1:0] cur;
    cur = {bus.out_robid, bus.out_prd, bus.out_result};
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && bus.out_valid) check("hold", cur, held);
      if (bus.out_valid && bus.out_ready) begin
        check("q_nonempty", W'(exp_q.size() != 0), W'(1));
        if (exp_q.size() != 0) check("result", cur, exp_q.pop_front());
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      held = cur;
    end
  end

  initial begin
    logic [13:0] rt [5];
    logic [63:0] a, b, e;
    int k;
    int lat;
    rt = '{T_ADD, T_SUB, T_XOR, T_OR, T_AND};

    reset = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_alu_type = T_ADD;
    bus.in_src1 = 64'd1;
    bus.in_src2 = 64'd2;
    bus.in_imm = '0;
    bus.in_pc = '0;
    bus.in_is_word = 1'b0;
    bus.in_is_unsigned = 1'b0;
    bus.in_is_imm = 1'b0;
    bus.in_robid = 7'd0;
    bus.in_prd = 6'd0;
    bus.flush_valid = 1'b0;
    bus.flush_robid = '0;
    bus.out_ready = 1'b1;

    // reset with in_valid held high
    @(posedge clock);
    @(negedge clock);
    check("rst_out_valid", W'(bus.out_valid), W'(0));
    @(posedge clock);
    #1;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clock);
    check("rst_in_ready", W'(bus.in_ready), W'(1));
    check("rst_out_valid2", W'(bus.out_valid), W'(0));
    check("rst_out_data", {bus.out_robid, bus.out_prd, bus.out_result}, W'(0));
    @(posedge clock);
    #1;

    // latency of the first op
    op(T_ADD, 64'd2, 64'd3, 1'b0, 1'b0, 7'd1, 64'd5);
    lat = 1;
    @(negedge clock);
    while (!bus.out_valid && lat < 20) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
    end
    check("latency", W'(lat), W'(STAGES));
    drain("drain_lat");

    // directed ALU ops
    op(T_ADD, 64'h7FFF_FFFF, 64'd1, 1'b1, 1'b0, 7'd2, 64'hFFFF_FFFF_8000_0000);
    op(T_SUB, 64'd5, 64'd7, 1'b0, 1'b0, 7'd3, 64'hFFFF_FFFF_FFFF_FFFE);
    op(T_SLT, '1, 64'd1, 1'b0, 1'b1, 7'd4, 64'd0);
    op(T_SLT, '1, 64'd1, 1'b0, 1'b0, 7'd5, 64'd1);
    op(T_SRA, 64'h8000_0000, 64'd4, 1'b1, 1'b0, 7'd6, 64'hFFFF_FFFF_F800_0000);
    op(T_SRL, '1, 64'd63, 1'b0, 1'b0, 7'd7, 64'd1);
    sendx(T_AUIPC, 64'hDEAD, 64'hBEEF, 64'h2000, 48'h1000, 1'b0, 1'b0, 1'b0, 7'd8, 64'h3000, 1'b1);
    sendx(T_LUI, 64'd5, 64'd6, 64'hFFFF_FFFF_1234_5000, 48'd0, 1'b0, 1'b0, 1'b1, 7'd9,
          64'hFFFF_FFFF_1234_5000, 1'b1);
    sendx(T_ADD, 64'd10, 64'd99, 64'hFFFF_FFFF_FFFF_FFFD, 48'd0, 1'b0, 1'b0, 1'b1, 7'd10, 64'd7, 1'b1);
    op(T_SLL, 64'd1, 64'd31, 1'b1, 1'b0, 7'd11, 64'hFFFF_FFFF_8000_0000);
    op(T_SLL, 64'd1, 64'd63, 1'b0, 1'b0, 7'd12, 64'h8000_0000_0000_0000);
    op(T_SRL, 64'hFFFF_FFFF_8000_0000, 64'd4, 1'b1, 1'b0, 7'd13, 64'h0000_0000_0800_0000);
    op(T_SRA, 64'h8000_0000_0000_0000, 64'd60, 1'b0, 1'b0, 7'd14, 64'hFFFF_FFFF_FFFF_FFF8);
    op(T_SUB, 64'd0, 64'd1, 1'b1, 1'b0, 7'd15, '1);
    op(T_SLL, 64'd3, 64'd33, 1'b1, 1'b0, 7'd16, 64'd6);
    op(T_XOR, 64'hF0F0, 64'hFF00, 1'b0, 1'b0, 7'd17, 64'h0FF0);
    op(T_OR, 64'hF0F0, 64'hFF00, 1'b0, 1'b0, 7'd18, 64'hFFF0);
    op(T_AND, 64'hF0F0, 64'hFF00, 1'b0, 1'b0, 7'd19, 64'hF000);
    op(T_ADD | T_XOR, 64'd5, 64'd6, 1'b0, 1'b0, 7'd20, 64'd0);
    op(14'd0, 64'd5, 64'd6, 1'b0, 1'b0, 7'd21, 64'd0);
`ifdef ALU_ZBA_EN
    op(T_SH2, 64'd3, 64'd4, 1'b0, 1'b0, 7'd22, 64'd16);
`else
    op(T_SH2, 64'd3, 64'd4, 1'b0, 1'b0, 7'd22, 64'd0);
`endif
    op(T_SLT, 64'd1, '1, 1'b0, 1'b0, 7'd23, 64'd0);
    drain("drain_directed");

    // back-pressure mid-stream
    fork
      for (int i = 0; i < 8; i++) op(T_ADD, 64'(i * 3), 64'd100, 1'b0, 1'b0, 7'(i), 64'(i * 3 + 100));
      begin
        repeat (3) @(posedge clock);
        #1 bus.out_ready = 1'b0;
        repeat (5) @(posedge clock);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain("drain_bp");

    // flush at acceptance: 12 is younger than 11 and killed on entry
    op(T_ADD, 64'd10, 64'd0, 1'b0, 1'b0, 7'd10, 64'd10);
    op(T_ADD, 64'd11, 64'd0, 1'b0, 1'b0, 7'd11, 64'd11);
    bus.flush_valid = 1'b1;
    bus.flush_robid = 7'd11;
    sendx(T_ADD, 64'd12, 64'd0, 64'd0, 48'd0, 1'b0, 1'b0, 1'b0, 7'd12, 64'd12, 1'b0);
    bus.flush_valid = 1'b0;
    drain("drain_flush_in");

    // flush of a stalled first stage; the equal robid survives
    bus.out_ready = 1'b0;
    op(T_ADD, 64'd20, 64'd0, 1'b0, 1'b0, 7'd20, 64'd20);
    sendx(T_ADD, 64'd21, 64'd0, 64'd0, 48'd0, 1'b0, 1'b0, 1'b0, 7'd21, 64'd21, 1'b0);
    pulse_flush(7'd20);
    bus.out_ready = 1'b1;
    drain("drain_flush_s0");

    // wrap case: {1,0x3F} kills {0,0x02} held in the output stage under back-pressure
    bus.out_ready = 1'b0;
    sendx(T_XOR, 64'd2, 64'd0, 64'd0, 48'd0, 1'b0, 1'b0, 1'b0, 7'h02, 64'd2, 1'b0);
    op(T_XOR, 64'h7F, 64'd0, 1'b0, 1'b0, 7'h7F, 64'h7F);
    pulse_flush(7'h7F);
    @(negedge clock);
    check("flush_out_stage", W'(bus.out_valid), W'(0));
    @(posedge clock);
    #1 bus.out_ready = 1'b1;
    drain("drain_flush_wrap");

    // reset with ops in flight
    bus.out_ready = 1'b0;
    sendx(T_ADD, 64'd40, 64'd0, 64'd0, 48'd0, 1'b0, 1'b0, 1'b0, 7'd40, 64'd40, 1'b0);
    sendx(T_ADD, 64'd41, 64'd0, 64'd0, 48'd0, 1'b0, 1'b0, 1'b0, 7'd41, 64'd41, 1'b0);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clock);
    check("rst_mid_out_valid", W'(bus.out_valid), W'(0));
    check("rst_mid_in_ready", W'(bus.in_ready), W'(1));
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_mid_quiet", W'(bus.out_valid), W'(0));
    @(posedge clock);
    #1;

    // random stream with random writeback stalls
    fork
      for (int i = 0; i < 30; i++) begin
        k = $urandom_range(0, 4);
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        case (k)
          0: e = a + b;
          1: e = a - b;
          2: e = a ^ b;
          3: e = a | b;
          default: e = a & b;
        endcase
        op(rt[k], a, b, 1'b0, 1'b0, 7'(i), e);
      end
      begin
        for (int j = 0; j < 50; j++) begin
          #1 bus.out_ready = 1'($urandom_range(0, 1));
          @(posedge clock);
        end
        #1 bus.out_ready = 1'b1;
      end
    join
    bus.out_ready = 1'b1;
    drain("drain_random");

    repeat (4) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
